vga_charmap_scaler: RTL
=======================

// Module: vga_charmap_scaler
// PURPOSE
//  Parametrised VGA timing + bitmap display engine: next-generation 1-bpp glyph/bitmap scan-out.
//  Generates H/V sync; renders a COLS x ROWS bit array inside a positioned window, each bit SCALE x SCALE pixels.
//  Colours are programmable FG/BG. vdata is snapshotted once per frame (tear-free).
//  Sits between the video-data memory/register and the VGA DAC pins.
// PARAMETERS
//  H_ACTIVE 640  visible pixels per line      | H_FP 16  | H_PULSE 96 | H_BP 48  (pixel clocks)
//  V_ACTIVE 480  visible lines per frame      | V_FP 10  | V_PULSE 2  | V_BP 33  (lines)
//  COLS 8   bitmap columns;  ROWS 8   bitmap rows;  SCALE 8   pixels per bit edge (>=1)
//  X0 288   window left edge, visible coordinates;  Y0 208   window top edge, visible coordinates
//  SYNC_NEG 1   1 = sync pulses active-low; 0 = active-high
// PORTS
//  dclk         in   1            pixel clock (25 MHz for defaults)
//  clr          in   1            reset: synchronous, active-high
//  vdata        in   COLS*ROWS    bitmap; bit index = row*COLS + col
//  fg_color     in   12           {R,G,B} 4b each, for bit = 1
//  bg_color     in   12           {R,G,B} for bit = 0 inside window
//  hsync        out  1            horizontal sync
//  vsync        out  1            vertical sync
//  red          out  4            red DAC
//  green        out  4            green DAC
//  blue         out  4            blue DAC
//  active       out  1            1 while (hc,vc) is in the visible area
//  frame_start  out  1            1-cycle pulse at the first visible pixel (0,0)
// BEHAVIOUR
//  - Counters: hc 0..H_TOTAL-1, vc 0..V_TOTAL-1 (H_TOTAL = sum of H_*; V_TOTAL = sum of V_*).
//    hc wraps to 0 and increments vc; vc wraps to 0 after V_TOTAL-1. Visible area is hc<H_ACTIVE, vc<V_ACTIVE.
//  - Sync asserted for hc in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_PULSE), vc likewise; SYNC_NEG selects level.
//  - Window: X0 <= hc < X0+COLS*SCALE and Y0 <= vc < Y0+ROWS*SCALE (half-open, no off-by-one gap).
//  - No dividers: col/sub-x counters step per pixel inside window; row/sub-y step per line.
//    All of them reset at window entry (col/sub-x) or at frame wrap (row/sub-y).
//  - Pixel colour: in window -> shadow[row*COLS+col] ? fg_color : bg_color; otherwise 12'h000.
//    Also 12'h000 outside the visible area.
//  - Shadow register: loads vdata on the cycle the counters move to (hc=0, vc=V_ACTIVE), i.e. at start of vblank.
//    A vdata change mid-frame is never visible until the next frame.
//  - Pipeline: all outputs registered. Outputs at cycle t+1 reflect counter state at cycle t.
//    Syncs, colours, active and frame_start share that single-cycle latency, so they stay mutually aligned.
//  - fg_color/bg_color are sampled live (same cycle as the bit lookup).
//  - Reset (sync, any time incl. mid-line):
//    hc=vc=0; all window counters 0; shadow=0.
//    Outputs on the next edge: red=green=blue=0, active=0, frame_start=0, hsync=vsync=inactive level.
//    The first frame after clr deasserts starts at (0,0) and shows an all-bg window.
//  - Window exceeding the visible area is clipped; bits beyond the visible edge are never indexed out of range.
// TESTING
//  1 Defaults, clr 1 cyc then free run -> hsync low exactly 96 cyc per 800-cyc line (hc 656..751).
//    vsync low for 2 lines (vc 490..491); frame = 420000 cyc; frame_start period 420000.
//  2 vdata=64'h1, fg=12'hFFF, bg=12'h00F -> pixels (288..295, 208..215) = FFF.
//    Rest of the 64x64 window = 00F; (287,208) and (352,208) = 000.
//  3 vdata=64'h8000_0000_0000_0000 -> only (344..351, 264..271) = fg.
//    Checks row*COLS+col ordering and the last-bit boundary.
//  4 Change vdata at vc=300 -> current frame unchanged; new image from the next frame_start.
//  5 SCALE=1, COLS=ROWS=4, X0=Y0=0 -> bit k maps to pixel (k%4, k/4); red/green/blue 0 at hc>=4.
//  6 clr asserted at hc=400, vc=100 for 1 cyc -> next cycle: outputs at reset values, counters 0.
//    First frame_start comes 1 cyc after release. SYNC_NEG=0 run: sync polarity inverted, same timing.

Source files
------------

// File: rtl/vga_charmap_scaler.sv
// VGA timing generator with a scaled 1-bpp bitmap window and per-frame shadowed bitmap.
// All outputs are registered one cycle behind the raster counters.
module vga_charmap_scaler #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_PULSE  = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_PULSE  = 2,
    parameter int V_BP     = 33,
    parameter int COLS     = 8,
    parameter int ROWS     = 8,
    parameter int SCALE    = 8,
    parameter int X0       = 288,
    parameter int Y0       = 208,
    parameter bit SYNC_NEG = 1'b1
) (
    input  logic                   dclk,
    input  logic                   clr,
    input  logic [COLS*ROWS-1:0]   vdata,
    input  logic [11:0]            fg_color,
    input  logic [11:0]            bg_color,
    output logic                   hsync,
    output logic                   vsync,
    output logic [3:0]             red,
    output logic [3:0]             green,
    output logic [3:0]             blue,
    output logic                   active,
    output logic                   frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_PULSE + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_PULSE + V_BP;
    localparam int HC_W    = $clog2(H_TOTAL);
    localparam int VC_W    = $clog2(V_TOTAL);
    localparam int COL_W   = $clog2(COLS + 1);
    localparam int ROW_W   = $clog2(ROWS + 1);
    localparam int SX_W    = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam int NBITS   = COLS * ROWS;
    localparam int IDX_W   = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic SYNC_OFF = SYNC_NEG;

    logic [HC_W-1:0]  hc_r;
    logic [VC_W-1:0]  vc_r;
    logic [COL_W-1:0] col_r;
    logic [SX_W-1:0]  subx_r;
    logic [ROW_W-1:0] row_r;
    logic [SX_W-1:0]  suby_r;
    logic [NBITS-1:0] shadow_r;

    logic             line_end_s;
    logic             frame_end_s;
    logic             visible_s;
    logic             in_x_s;
    logic             in_y_s;
    logic             win_s;
    logic             hs_on_s;
    logic             vs_on_s;
    logic [IDX_W-1:0] idx_s;
    logic             bit_s;
    logic [11:0]      pix_s;

    // Raster decode: wrap points, sync windows, bitmap window and pixel colour.
    always_comb begin
        line_end_s  = (int'(hc_r) == H_TOTAL - 1);
        frame_end_s = line_end_s && (int'(vc_r) == V_TOTAL - 1);
        visible_s   = (int'(hc_r) < H_ACTIVE) && (int'(vc_r) < V_ACTIVE);
        in_x_s      = (int'(hc_r) >= X0) && (int'(hc_r) < X0 + COLS * SCALE);
        in_y_s      = (int'(vc_r) >= Y0) && (int'(vc_r) < Y0 + ROWS * SCALE);
        win_s       = in_x_s && in_y_s && visible_s;
        hs_on_s     = (int'(hc_r) >= H_ACTIVE + H_FP) && (int'(hc_r) < H_ACTIVE + H_FP + H_PULSE);
        vs_on_s     = (int'(vc_r) >= V_ACTIVE + V_FP) && (int'(vc_r) < V_ACTIVE + V_FP + V_PULSE);
        idx_s       = IDX_W'(int'(row_r) * COLS + int'(col_r));
        // Range guard keeps a clipped or overrunning window from indexing past the bitmap.
        if (win_s && (int'(row_r) < ROWS) && (int'(col_r) < COLS)) begin
            bit_s = shadow_r[idx_s];
        end else begin
            bit_s = 1'b0;
        end
        if (win_s) begin
            pix_s = bit_s ? fg_color : bg_color;
        end else begin
            pix_s = 12'h000;
        end
    end

    // Horizontal and vertical raster counters.
    always_ff @(posedge dclk) begin
        if (clr) begin
            hc_r <= {HC_W{1'b0}};
            vc_r <= {VC_W{1'b0}};
        end else if (line_end_s) begin
            hc_r <= {HC_W{1'b0}};
            vc_r <= frame_end_s ? {VC_W{1'b0}} : vc_r + VC_W'(1);
        end else begin
            hc_r <= hc_r + HC_W'(1);
        end
    end

    // Bitmap column/row counters: column restarts at window entry, row at frame wrap.
    always_ff @(posedge dclk) begin
        if (clr) begin
            col_r  <= {COL_W{1'b0}};
            subx_r <= {SX_W{1'b0}};
            row_r  <= {ROW_W{1'b0}};
            suby_r <= {SX_W{1'b0}};
        end else begin
            if (!in_x_s || line_end_s) begin
                col_r  <= {COL_W{1'b0}};
                subx_r <= {SX_W{1'b0}};
            end else if (int'(subx_r) == SCALE - 1) begin
                col_r  <= col_r + COL_W'(1);
                subx_r <= {SX_W{1'b0}};
            end else begin
                subx_r <= subx_r + SX_W'(1);
            end
            if (frame_end_s) begin
                row_r  <= {ROW_W{1'b0}};
                suby_r <= {SX_W{1'b0}};
            end else if (line_end_s && in_y_s) begin
                if (int'(suby_r) == SCALE - 1) begin
                    row_r  <= row_r + ROW_W'(1);
                    suby_r <= {SX_W{1'b0}};
                end else begin
                    suby_r <= suby_r + SX_W'(1);
                end
            end else begin
                row_r  <= row_r;
                suby_r <= suby_r;
            end
        end
    end

    // Bitmap shadow: captured as the raster enters vertical blanking.
    always_ff @(posedge dclk) begin
        if (clr) begin
            shadow_r <= {NBITS{1'b0}};
        end else if (line_end_s && (int'(vc_r) == V_ACTIVE - 1)) begin
            shadow_r <= vdata;
        end else begin
            shadow_r <= shadow_r;
        end
    end

    // Registered outputs, all reflecting the same counter state.
    always_ff @(posedge dclk) begin
        if (clr) begin
            hsync       <= SYNC_OFF;
            vsync       <= SYNC_OFF;
            red         <= 4'h0;
            green       <= 4'h0;
            blue        <= 4'h0;
            active      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hsync       <= hs_on_s ^ SYNC_OFF;
            vsync       <= vs_on_s ^ SYNC_OFF;
            red         <= pix_s[11:8];
            green       <= pix_s[7:4];
            blue        <= pix_s[3:0];
            active      <= visible_s;
            frame_start <= (hc_r == {HC_W{1'b0}}) && (vc_r == {VC_W{1'b0}});
        end
    end

endmodule
